// File: rtl/booth_r4_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready on both sides,
// signed or unsigned operands chosen per transaction, full 2*WIDTH product.
module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int D  = WIDTH / 2 + 1;   // Booth digits over the WIDTH+2 extended multiplier
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(D);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [AW-1:0]       acc_r;
  logic [AW-1:0]       mcand_r;
  logic [EW:0]         ysh_r;
  logic [CW-1:0]       cnt_r;
  logic [2*WIDTH-1:0]  p_r;
  logic                out_valid_r;

  logic [EW-1:0]       x_ext_s;
  logic [EW-1:0]       y_ext_s;
  logic [AW-1:0]       pp_s;
  logic [AW-1:0]       sum_s;

  // Partial product for one Booth window; the multiplicand is already weighted by 4^i.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] win, input logic [AW-1:0] m);
    case (win)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m << 1;
      3'b100:         booth_pp = -(m << 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = {AW{1'b0}};
    endcase
  endfunction

  assign x_ext_s   = {{2{is_signed & x[WIDTH-1]}}, x};
  assign y_ext_s   = {{2{is_signed & y[WIDTH-1]}}, y};
  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign p         = p_r;

  // Current digit's contribution and the running sum it produces.
  always_comb begin
    pp_s  = booth_pp(ysh_r[2:0], mcand_r);
    sum_s = acc_r + pp_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == {CW{1'b0}}) state_s = DONE;
        else                     state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath: operand load on accept, one digit per RUN cycle, product hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= {AW{1'b0}};
      mcand_r     <= {AW{1'b0}};
      ysh_r       <= {(EW+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      p_r         <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            acc_r   <= {AW{1'b0}};
            mcand_r <= {{(AW-EW){x_ext_s[EW-1]}}, x_ext_s};
            ysh_r   <= {y_ext_s, 1'b0};
            cnt_r   <= CW'(D - 1);
          end
        end
        RUN: begin
          acc_r   <= sum_s;
          mcand_r <= mcand_r << 2;
          ysh_r   <= ysh_r >> 2;
          cnt_r   <= cnt_r - CW'(1'b1);
          if (cnt_r == {CW{1'b0}}) begin
            p_r         <= sum_s[2*WIDTH-1:0];
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Directed and swept checks of booth_r4_mult_seq at WIDTH=4, 8 and 16 with immediate assertions.
module tb_booth_r4_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [15:0] xv, yv;
  logic        sv;
  logic        ordy;
  logic        ov4, ov8, ov16, ir4, ir8, ir16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  booth_r4_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4), .x(xv[3:0]), .y(yv[3:0]),
    .is_signed(sv), .out_valid(ov4), .out_ready(ordy), .p(p4));
  booth_r4_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8), .x(xv[7:0]), .y(yv[7:0]),
    .is_signed(sv), .out_valid(ov8), .out_ready(ordy), .p(p8));
  booth_r4_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir16), .x(xv), .y(yv),
    .is_signed(sv), .out_valid(ov16), .out_ready(ordy), .p(p16));

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? ov4 : (sel == 1) ? ov8 : ov16;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 0) ? ir4 : (sel == 1) ? ir8 : ir16;
  endfunction

  function automatic logic [31:0] get_p(input int sel);
    return (sel == 0) ? {24'd0, p4} : (sel == 1) ? {16'd0, p8} : p16;
  endfunction

  // Reference product: interpret the low w bits as signed or unsigned, multiply, keep 2w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    longint av, bv, pr;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    pr = av * bv;
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full transaction: optional idle gap, accept, latency/busy checks, product check,
  // optional backpressure hold with ignored in_valid pulses, then the output handshake.
  task automatic txn(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [31:0] exp, input string tag, input int gin, input int hold);
    int n;
    logic busy_ok, hold_ok;
    logic [31:0] pk;
    iv = 3'b000;
    repeat (gin) begin @(posedge clk); #1; end
    check({tag, "/in_ready"}, get_ir(sel), 1'b1);
    xv = a; yv = b; sv = s; iv = 3'b001 << sel;
    @(posedge clk); #1;
    iv = 3'b000; xv = 16'($urandom); yv = 16'($urandom); sv = ~s;
    n = 0; busy_ok = 1'b1;
    while (!get_ov(sel) && n < 40) begin
      if (get_ir(sel)) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    check({tag, "/latency"}, n, width_of(sel) / 2 + 1);
    check({tag, "/busy"}, busy_ok, 1'b1);
    check({tag, "/p"}, get_p(sel), exp);
    pk = get_p(sel); hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      iv = (i % 2 == 0) ? (3'b001 << sel) : 3'b000;
      xv = 16'($urandom); yv = 16'($urandom);
      @(posedge clk); #1;
      if (!get_ov(sel) || get_ir(sel) || get_p(sel) !== pk) hold_ok = 1'b0;
    end
    iv = 3'b000;
    if (hold > 0) check({tag, "/hold"}, hold_ok, 1'b1);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "/ov_drop"}, get_ov(sel), 1'b0);
    check({tag, "/ready_back"}, get_ir(sel), 1'b1);
    check({tag, "/p_kept"}, get_p(sel), exp);
  endtask

  initial begin
    logic quiet_ok;
    logic [15:0] ra, rb;
    logic rs;
    rst = 1'b1; iv = 3'b000; xv = 16'd0; yv = 16'd0; sv = 1'b0; ordy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst/ov8", ov8, 1'b0);
    check("rst/ir8", ir8, 1'b1);
    check("rst/p8", p8, 16'h0000);
    check("rst/ov16", ov16, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed WIDTH=8 vectors
    txn(1, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000, "s_min_sq", 0, 0);
    txn(1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, "u_ones_sq", 1, 0);
    txn(1, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001, "s_m1_sq", 0, 0);
    txn(1, 16'h0007, 16'h00FD, 1'b1, 32'h0000_FFEB, "s_7_m3", 2, 0);
    txn(1, 16'h0000, 16'h005A, 1'b1, 32'h0000_0000, "zero", 0, 0);
    txn(1, 16'h0012, 16'h0034, 1'b0, 32'h0000_03A8, "backpressure", 0, 10);

    // Reset while digit 2 is being processed
    xv = 16'h00C8; yv = 16'h0064; sv = 1'b0; iv = 3'b010;
    @(posedge clk); #1;
    iv = 3'b000;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("midrst/ov8", ov8, 1'b0);
    check("midrst/p8", p8, 16'h0000);
    check("midrst/ir8", ir8, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet_ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov8 || !ir8) quiet_ok = 1'b0;
    end
    check("midrst/quiet", quiet_ok, 1'b1);
    txn(1, 16'd12, 16'd10, 1'b0, 32'd120, "after_rst", 0, 0);

    // WIDTH=16 boundaries
    txn(2, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_s_min", 0, 0);
    txn(2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "w16_u_ones", 0, 2);
    txn(2, 16'd12345, 16'hFEBF, 1'b1, 32'hFFC3_8887, "w16_s_mix", 1, 0);

    // Exhaustive WIDTH=4, both modes, random gaps
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          txn(0, 16'(a), 16'(b), 1'(s), ref_prod(4, 16'(a), 16'(b), 1'(s)), "w4",
              $urandom_range(0, 2), $urandom_range(0, 2));

    // Random WIDTH=8 and WIDTH=16
    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      txn(1, ra, rb, rs, ref_prod(8, ra, rb, rs), "w8_rand", $urandom_range(0, 2),
          $urandom_range(0, 3));
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      txn(2, ra, rb, rs, ref_prod(16, ra, rb, rs), "w16_rand", $urandom_range(0, 2),
          $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_r4_mult_seq.md
Name: booth_r4_mult_seq

Overview:
Parametrised iterative radix-4 Booth multiplier. It is the successor to the team's radix-2 sequential Booth multiplier.
- Retires 2 multiplier bits per cycle.
- Supports signed and unsigned operands, selected per transaction.
- Uses valid/ready handshakes on input and output so it drops into streaming datapaths.
- Product is full width (2*WIDTH), exact, never truncated.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise)

Ports:
clk        input   1          clock, rising edge
rst        input   1          asynchronous reset, active-high
in_valid   input   1          operands/mode valid
in_ready   output  1          block can accept operands
x          input   WIDTH      multiplicand
y          input   WIDTH      multiplier
is_signed  input   1          1: two's-complement operands; 0: unsigned
out_valid  output  1          product valid
out_ready  input   1          consumer accepts product
p          output  2*WIDTH    product x*y

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, p=0, all internal registers 0.
- States and transitions:
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE after the last digit is processed.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE), combinational from state only.
- Accept (IDLE, in_valid=1), same edge:
  - Latch x, y and is_signed.
  - Extend both operands to WIDTH+2 bits: sign-extend if is_signed=1, zero-extend if 0.
  - Clear the accumulator; load the multiplier shift register with extended y and an appended 0 LSB (the Booth "y[-1]").
  - Load digit counter = D-1, where D = WIDTH/2+1.
- RUN, one digit per cycle:
  - Inspect the 3-bit window {y[2i+1], y[2i], y[2i-1]}.
  - Digit map: 000,111 -> 0; 001,010 -> +X; 011 -> +2X; 100 -> -2X; 101,110 -> -X.
  - Add the selected partial product, weighted 4^i, into a 2*WIDTH+4-bit accumulator.
  - Arithmetic right shift of accumulator/multiplier by 2 per cycle is an acceptable equivalent.
  - -X and -2X are formed as two's complement of the extended X; no separate carry-in tracking outside the accumulator.
  - After D RUN cycles the accumulator holds the exact product; p <= accumulator[2*WIDTH-1:0]; enter DONE.
- Latency:
  - Acceptance at edge k; RUN edges k+1..k+D; out_valid=1 after edge k+D.
  - WIDTH=8: D=5, so out_valid rises 5 edges after accept.
- DONE:
  - out_valid=1; p stable and unchanged while out_ready=0 (backpressure, held indefinitely).
  - Edge with out_ready=1: out_valid<=0, state<=IDLE. p keeps its last value.
- Throughput:
  - One product per D+2 cycles with out_ready tied high: accept, D RUN cycles, DONE.
  - No overlap: in_ready=0 throughout RUN and DONE.
- in_valid during RUN/DONE:
  - Ignored; operands not sampled.
  - Upstream must hold its data (standard valid/ready).
- x, y, is_signed changes after acceptance have no effect on the in-flight product.
- Boundary cases:
  - Signed most-negative values (-2^(WIDTH-1)) must be exact; the WIDTH+2 extension guarantees no overflow of ±2X.
  - Unsigned all-ones operands must be exact.
  - Zero operands take the same D cycles; no early termination.
- Reset mid-operation:
  - Aborts immediately to IDLE with out_valid=0 and p=0.
  - The in-flight transaction is lost; no spurious out_valid after release.

Test Plan:
1. WIDTH=8, signed, x=-128 (0x80), y=-128 -> p=0x4000 (16384). out_valid rises exactly 5 edges after accept. in_ready low during RUN/DONE.
2. WIDTH=8, unsigned, x=0xFF, y=0xFF -> p=0xFE01 (65025). Then signed x=0xFF (-1), y=0xFF -> p=0x0001.
3. WIDTH=8, signed: x=7, y=-3 -> p=0xFFEB (-21). Then x=0, y=0x5A -> p=0, same latency.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles after out_valid.
   - Required: p and out_valid stable; in_valid pulses with new operands are ignored (in_ready=0).
   - Release out_ready: one-cycle handshake, then in_ready=1 the next cycle.
5. Reset mid-RUN: assert rst asynchronously at RUN digit 2 -> out_valid=0, p=0, in_ready=1 immediately. Next transaction (unsigned 12*10) returns p=120.
6. Random sweep at WIDTH=4, 8, 16 (exhaustive at WIDTH=4), both modes, with random in_valid/out_ready gaps -> p matches a reference model. Each transaction completes; none dropped or duplicated.
